// File: rtl/cdb_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_rr_arbiter_if
// Bundles the functional-unit result ports and the common-data-bus broadcast
// lanes of the CDB round-robin arbiter.
//   fub_valid      FU i has a result this cycle
//   fub_tagDest    destination tag per FU, FU i at [i*TAG_W +: TAG_W]
//   fub_result     result value per FU, FU i at [i*DATA_W +: DATA_W]
//   fub_stall      FU i was not granted and must hold its inputs
//   cdb_rd_en      lane k broadcasting (registered)
//   cdb_rd         tag on lane k (registered)
//   cdb_reg_value  value on lane k (registered)
// Modports: slave = arbiter side, master = functional-unit / consumer side.
// -----------------------------------------------------------------------------
interface cdb_rr_arbiter_if #(
  parameter int NUM_FUB = 8,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 64
);
  logic [NUM_FUB-1:0]        fub_valid;
  logic [NUM_FUB*TAG_W-1:0]  fub_tagDest;
  logic [NUM_FUB*DATA_W-1:0] fub_result;
  logic [NUM_FUB-1:0]        fub_stall;
  logic [NUM_CDB-1:0]        cdb_rd_en;
  logic [NUM_CDB*TAG_W-1:0]  cdb_rd;
  logic [NUM_CDB*DATA_W-1:0] cdb_reg_value;

  modport slave (
    input  fub_valid, fub_tagDest, fub_result,
    output fub_stall, cdb_rd_en, cdb_rd, cdb_reg_value
  );

  modport master (
    output fub_valid, fub_tagDest, fub_result,
    input  fub_stall, cdb_rd_en, cdb_rd, cdb_reg_value
  );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_rr_arbiter
// Registered common-data-bus arbiter. NUM_FUB functional-unit result ports
// compete for NUM_CDB broadcast lanes each cycle under rotating priority.
// Losers are stalled combinationally; winners are registered and broadcast on
// the following cycle. A flush squashes the cycle's requests and clears the
// broadcast enables and the priority pointer.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   flush    synchronous squash (mispredict recovery)
//   bus      cdb_rr_arbiter_if.slave: FU requests in, stalls and CDB lanes out
// -----------------------------------------------------------------------------
module cdb_rr_arbiter #(
  parameter int NUM_FUB = 8,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  cdb_rr_arbiter_if.slave  bus
);

  localparam int PTR_W = (NUM_FUB > 1) ? $clog2(NUM_FUB) : 1;
  localparam int IDX_W = PTR_W + 1;

  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [NUM_CDB-1:0]        en_q, en_d;
  logic [NUM_CDB*TAG_W-1:0]  rd_q, rd_d;
  logic [NUM_CDB*DATA_W-1:0] val_q, val_d;

  logic [TAG_W-1:0]  tagArr  [NUM_FUB];
  logic [DATA_W-1:0] resArr  [NUM_FUB];
  logic [PTR_W-1:0]  scanIdx [NUM_FUB];

  logic [NUM_FUB-1:0] grant;
  logic [NUM_CDB-1:0] laneVld;
  logic [PTR_W-1:0]   laneSrc [NUM_CDB];
  logic [PTR_W-1:0]   lastIdx;
  logic               anyGrant;
  logic               arbEnable;
  int                 grantCnt;

  // scanIdx[k] is the FU visited k-th, starting at the pointer. The extra sum
  // bit plus an explicit subtract keeps the wrap correct for non-power-of-2
  // NUM_FUB.
  for (genvar i = 0; i < NUM_FUB; i++) begin : g_fub
    logic [IDX_W-1:0] sum;
    assign tagArr[i]  = bus.fub_tagDest[i*TAG_W +: TAG_W];
    assign resArr[i]  = bus.fub_result[i*DATA_W +: DATA_W];
    assign sum        = {1'b0, ptr_q} + IDX_W'(i);
    assign scanIdx[i] = (sum >= IDX_W'(NUM_FUB)) ? PTR_W'(sum - IDX_W'(NUM_FUB))
                                                 : sum[PTR_W-1:0];
  end

  // No grants while in reset or during a flush.
  assign arbEnable = reset_n & ~flush;

  // Grant the first NUM_CDB valid FUs in scan order, packing lanes from 0.
  always_comb begin
    grant    = '0;
    laneVld  = '0;
    lastIdx  = ptr_q;
    anyGrant = 1'b0;
    grantCnt = 0;
    for (int j = 0; j < NUM_CDB; j++) laneSrc[j] = '0;
    for (int k = 0; k < NUM_FUB; k++) begin
      if (arbEnable && bus.fub_valid[scanIdx[k]] && (grantCnt < NUM_CDB)) begin
        grant[scanIdx[k]] = 1'b1;
        for (int j = 0; j < NUM_CDB; j++) begin
          if (grantCnt == j) begin
            laneVld[j] = 1'b1;
            laneSrc[j] = scanIdx[k];
          end
        end
        lastIdx  = scanIdx[k];
        anyGrant = 1'b1;
        grantCnt = grantCnt + 1;
      end
    end
  end

  // Flush discards requests (no stall) but reset still reports them as stalled.
  assign bus.fub_stall = (reset_n && flush) ? '0 : (bus.fub_valid & ~grant);

  // Next-state: pointer moves past the last winner; unused lanes keep old data.
  always_comb begin
    if (flush) begin
      ptr_d = '0;
    end else if (anyGrant) begin
      ptr_d = (lastIdx == PTR_W'(NUM_FUB - 1)) ? '0 : (lastIdx + PTR_W'(1));
    end else begin
      ptr_d = ptr_q;
    end
    en_d  = laneVld;
    rd_d  = rd_q;
    val_d = val_q;
    for (int j = 0; j < NUM_CDB; j++) begin
      if (laneVld[j]) begin
        rd_d[j*TAG_W +: TAG_W]   = tagArr[laneSrc[j]];
        val_d[j*DATA_W +: DATA_W] = resArr[laneSrc[j]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      en_q  <= '0;
      rd_q  <= '0;
      val_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      en_q  <= en_d;
      rd_q  <= rd_d;
      val_q <= val_d;
    end
  end

  assign bus.cdb_rd_en     = en_q;
  assign bus.cdb_rd        = rd_q;
  assign bus.cdb_reg_value = val_q;

endmodule
